mac_vector_accumulator: RTL
===========================

# mac_vector_accumulator

Sequential dot-product stage sitting directly downstream of the 4x4 combinational multiplier in the ALU datapath. Accepts 4-bit operand pairs over a valid/ready handshake, routes them to the multiplier, and accumulates the 8-bit products into a wide sum. After LEN terms, or an early `in_last`, it presents the result on a valid/ready output. It is the first clocked stage of the multiply path.

## Interface
- `LEN`, 4: terms per vector; legal range 2..16.
- `ACC_W`, 8 + $clog2(LEN): accumulator width; sized so a full vector of 15*15 products never overflows.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: block can accept a term this cycle.
- `in_a` input 4: multiplicand.
- `in_b` input 4: multiplier.
- `in_last` input 1: this term closes the vector early; sampled only on an accepted term.
- `clear` input 1: synchronous abort of the current vector.
- `mul_a` output 4: to multiplier A. Combinational copy of `in_a`.
- `mul_b` output 4: to multiplier B. Combinational copy of `in_b`.
- `mul_p` input 8: product returned combinationally by the multiplier in the same cycle.
- `out_valid` output 1: result held on `out_sum`.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output ACC_W: dot-product result.
- `out_terms` output 5: number of terms in `out_sum` (1..LEN).

## Operation
- States:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- Accept occurs when `in_valid` && `in_ready`.
- On an accept in ACCUM:
  - acc <= acc + zero-extended `mul_p`; cnt <= cnt + 1.
  - If cnt == LEN-1 or `in_last`=1: `out_sum` <= acc + `mul_p`, `out_terms` <= cnt + 1, acc <= 0, cnt <= 0, next state DONE.
- DONE with `out_ready`=1: next state ACCUM. `out_sum` and `out_terms` keep their last value and are don't-care while `out_valid`=0.
- DONE with `out_ready`=0: hold all outputs stable.
- `clear`=1 in any state: acc <= 0, cnt <= 0, state <= ACCUM. `clear` has priority over an accept in the same cycle; that term is discarded. `clear` in DONE drops the pending result.
- Arithmetic is unsigned with no saturation. ACC_W guarantees no wrap for ≤LEN terms.
- `in_valid` with `in_ready`=0 is ignored; the upstream holds the data.
- `mul_a` and `mul_b` follow `in_a` and `in_b` at all times, independent of the handshake.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - state=ACCUM, acc=0, cnt=0
  - `out_valid`=0, `in_ready`=1
  - `out_sum`=0, `out_terms`=0
- Reset asserted mid-vector or in DONE discards everything; it has the same effect as `clear`.
- The product path in_a/in_b -> mul_a/mul_b -> multiplier -> mul_p -> acc adder is combinational within one cycle. It is the critical path.
- Latency: `out_valid` rises on the edge that accepts the final term, so it is visible the cycle after that term was presented.
- Throughput: one term per cycle in ACCUM. One dead input cycle per vector (DONE with immediate `out_ready`). A vector of LEN terms therefore takes at least LEN+1 cycles.
- `in_ready` depends only on the registered state. It never depends combinationally on `in_valid` or `out_ready`.

## Test plan
- LEN=4; apply pairs (3,5),(15,15),(0,9),(2,7) back-to-back with `out_ready`=1 -> `out_valid` one cycle after the 4th accept; `out_sum`=15+225+0+14=254, `out_terms`=4; `in_ready` is low for exactly one cycle.
- Apply four pairs of (15,15) -> `out_sum`=900 with no overflow (ACC_W=10). Then hold `out_ready`=0 for 5 cycles -> `out_valid`, `out_sum`, `out_terms` stable and `in_ready`=0 throughout.
- Apply (4,4) then (6,2) with `in_last`=1 on the second -> `out_sum`=28, `out_terms`=2. The next vector starts from acc=0.
- Apply (9,9) and (1,1), then assert `clear` in the same cycle as a valid (7,7) -> (7,7) is discarded; the next full vector of four (1,1) gives `out_sum`=4.
- Toggle `in_valid` randomly over 3 vectors against a reference sum model -> every `out_sum` matches; no term is dropped or double-counted.
- Pulse `rst_n` low for 1 cycle while in DONE and again mid-vector -> all outputs return to reset values; the subsequent vector of (2,3)x4 gives 24.

Source files
------------

// File: rtl/mac_vector_accumulator.sv
// Sequential dot-product stage: accumulates 4x4 multiplier products over a
// valid/ready input stream and presents each finished vector sum downstream.
module mac_vector_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 8 + $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    input  logic             clear,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [4:0]       out_terms
);

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic [ACC_W-1:0] acc_sum;
    logic             accept;
    logic             fin;

    // Operands go straight to the external multiplier regardless of handshake.
    assign mul_a   = in_a;
    assign mul_b   = in_b;
    assign acc_sum = acc + {{(ACC_W-8){1'b0}}, mul_p};
    assign accept  = in_valid && in_ready;
    assign fin     = accept && ((cnt == 5'(LEN-1)) || in_last);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        case (state)
            ACCUM: if (fin) state_n = DONE;
            DONE:  if (out_ready) state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
        // Abort wins over any accept or pending result in the same cycle.
        if (clear) state_n = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_terms <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (fin) begin
                out_sum   <= acc_sum;
                out_terms <= cnt + 5'd1;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule
